// File: rtl/daq_axil_pkg.sv
// Shared types for the DAQ register-map AXI4-Lite configuration master.
// Holds the FSM state encoding, the AXI response codes and the latched response status.
package daq_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic       write;
    logic [1:0] prot;
  } axil_cmd_hdr_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       timeout;
  } axil_rsp_stat_t;

endpackage

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite initiator turning a command stream into regmap accesses.
// Optional watchdog enabled by defining AXIL_CFG_TIMEOUT_EN (default build waits forever).
module axil_cfg_master
  import daq_axil_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                m_axi_ps_clk,
  input  logic                m_axi_ps_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_axi_ps_awaddr,
  output logic [2:0]          m_axi_ps_awprot,
  output logic                m_axi_ps_awvalid,
  input  logic                m_axi_ps_awready,
  output logic [DATA_W-1:0]   m_axi_ps_wdata,
  output logic [DATA_W/8-1:0] m_axi_ps_wstrb,
  output logic                m_axi_ps_wvalid,
  input  logic                m_axi_ps_wready,
  input  logic [1:0]          m_axi_ps_bresp,
  input  logic                m_axi_ps_bvalid,
  output logic                m_axi_ps_bready,
  output logic [ADDR_W-1:0]   m_axi_ps_araddr,
  output logic [2:0]          m_axi_ps_arprot,
  output logic                m_axi_ps_arvalid,
  input  logic                m_axi_ps_arready,
  input  logic [DATA_W-1:0]   m_axi_ps_rdata,
  input  logic [1:0]          m_axi_ps_rresp,
  input  logic                m_axi_ps_rvalid,
  output logic                m_axi_ps_rready
);

  axil_state_e         state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                bready_q, bready_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  axil_rsp_stat_t      rsp_stat_q, rsp_stat_d;
  logic                rsp_done;
  logic                aw_done, w_done;

  // Done flags look at the registered valid only, so ready never feeds a valid combinationally.
  assign aw_done  = !awvalid_q || m_axi_ps_awready;
  assign w_done   = !wvalid_q  || m_axi_ps_wready;
  assign rsp_done = (state_q == ST_WR_RESP && m_axi_ps_bvalid && bready_q) ||
                    (state_q == ST_RD_DATA && m_axi_ps_rvalid && rready_q);

`ifdef AXIL_CFG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             waiting;
  assign waiting = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_stat_d  = rsp_stat_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (awvalid_q && m_axi_ps_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_ps_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_ps_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_stat_d  = '{resp: m_axi_ps_bresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (m_axi_ps_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_ps_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi_ps_rdata;
          rsp_stat_d  = '{resp: m_axi_ps_rresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AXIL_CFG_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) tmo_cnt_d = '0;
    else if (waiting)       tmo_cnt_d = tmo_cnt_q + 1'b1;
    // Expiry aborts the transaction unless a real response lands on the same edge.
    if (waiting && tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !rsp_done) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_rdata_d = '0;
      rsp_stat_d  = '{resp: RESP_SLVERR, timeout: 1'b1};
      rsp_valid_d = 1'b1;
      state_d     = ST_RSP;
    end
`endif
  end

  always_ff @(posedge m_axi_ps_clk) begin
    if (!m_axi_ps_aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_stat_q  <= '0;
    end else begin
      state_q     <= state_d;
      // cmd_ready rises one cycle after reset release or after the response is taken.
      cmd_ready_q <= (state_q == ST_IDLE && !cmd_ready_q) ? 1'b1 : cmd_ready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_stat_q  <= rsp_stat_d;
    end
  end

`ifdef AXIL_CFG_TIMEOUT_EN
  always_ff @(posedge m_axi_ps_clk) begin
    if (!m_axi_ps_aresetn) tmo_cnt_q <= '0;
    else                   tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_resp         = rsp_stat_q.resp;
  assign rsp_timeout      = rsp_stat_q.timeout;
  assign m_axi_ps_awaddr  = awaddr_q;
  assign m_axi_ps_awprot  = 3'b000;
  assign m_axi_ps_awvalid = awvalid_q;
  assign m_axi_ps_wdata   = wdata_q;
  assign m_axi_ps_wstrb   = wstrb_q;
  assign m_axi_ps_wvalid  = wvalid_q;
  assign m_axi_ps_bready  = bready_q;
  assign m_axi_ps_araddr  = araddr_q;
  assign m_axi_ps_arprot  = 3'b000;
  assign m_axi_ps_arvalid = arvalid_q;
  assign m_axi_ps_rready  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a small delay-configurable AXI4-Lite slave.
// Define AXIL_CFG_TIMEOUT_EN to also exercise the watchdog (built with TIMEOUT_CYCLES=16).
module tb_axil_cfg_master;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  // Slave configuration and observation
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic        ar_en = 1'b1;
  logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
  logic [31:0] rdata_cfg = '0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
  logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0;
  logic [3:0]  got_wstrb = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axil_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_ps_clk(clk), .m_axi_ps_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_ps_awaddr(awaddr), .m_axi_ps_awprot(awprot), .m_axi_ps_awvalid(awvalid),
    .m_axi_ps_awready(awready), .m_axi_ps_wdata(wdata), .m_axi_ps_wstrb(wstrb),
    .m_axi_ps_wvalid(wvalid), .m_axi_ps_wready(wready), .m_axi_ps_bresp(bresp),
    .m_axi_ps_bvalid(bvalid), .m_axi_ps_bready(bready), .m_axi_ps_araddr(araddr),
    .m_axi_ps_arprot(arprot), .m_axi_ps_arvalid(arvalid), .m_axi_ps_arready(arready),
    .m_axi_ps_rdata(rdata), .m_axi_ps_rresp(rresp), .m_axi_ps_rvalid(rvalid),
    .m_axi_ps_rready(rready)
  );

  // Slave: each ready rises after its configured delay, one response after both AW and W.
  always @(posedge clk) begin
    if (!aresetn) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awready <= 1'b0; aw_cnt <= aw_cnt + 1; aw_got <= 1'b1; aw_wait <= 0; got_awaddr <= awaddr;
      end else if (awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) awready <= 1'b1; else aw_wait <= aw_wait + 1;
      end else aw_wait <= 0;
      if (wvalid && wready) begin
        wready <= 1'b0; w_cnt <= w_cnt + 1; w_got <= 1'b1; w_wait <= 0;
        got_wdata <= wdata; got_wstrb <= wstrb;
      end else if (wvalid && !w_got) begin
        if (w_wait >= w_delay) wready <= 1'b1; else w_wait <= w_wait + 1;
      end else w_wait <= 0;
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1; bresp <= bresp_cfg;
      end
      if (arvalid && arready) begin
        arready <= 1'b0; ar_cnt <= ar_cnt + 1; r_pend <= 1'b1; ar_wait <= 0; got_araddr <= araddr;
      end else if (arvalid && ar_en) begin
        if (ar_wait >= ar_delay) arready <= 1'b1; else ar_wait <= ar_wait + 1;
      end else ar_wait <= 0;
      if (rvalid && rready) begin
        rvalid <= 1'b0; r_pend <= 1'b0;
      end else if (r_pend && !rvalid) begin
        rvalid <= 1'b1; rdata <= rdata_cfg; rresp <= rresp_cfg;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st);
    bit done = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) check("cmd_accept_timeout", 0, 1);
    $display("cmd %s addr=0x%08h wdata=0x%08h wstrb=0x%0h accepted=%0d",
             wr ? "WR" : "RD", addr, wd, st, done);
  endtask

  task automatic wait_rsp(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (rsp_valid) seen = 1;
      else tick();
    end
    check("rsp_valid_seen", seen, 1);
  endtask

  task automatic take_rsp();
    $display("rsp rdata=0x%08h resp=%0d timeout=%0d", rsp_rdata, rsp_resp, rsp_timeout);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int aw0, w0;
    bit stable, no_rsp;
    logic [31:0] held;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr", awaddr, 0);
    aresetn = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write, awready two cycles ahead of wready
    aw_delay = 0; w_delay = 2; bresp_cfg = 2'b00;
    aw0 = aw_cnt; w0 = w_cnt;
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(40);
    check("wr1_resp", rsp_resp, 0);
    check("wr1_rdata", rsp_rdata, 0);
    check("wr1_timeout", rsp_timeout, 0);
    check("wr1_aw_count", aw_cnt - aw0, 1);
    check("wr1_w_count", w_cnt - w0, 1);
    check("wr1_awaddr", got_awaddr, 32'h10);
    check("wr1_wdata", got_wdata, 32'hDEAD_BEEF);
    check("wr1_wstrb", got_wstrb, 4'hF);
    check("wr1_awprot", awprot, 0);
    take_rsp();

    // Read with 3-cycle arready delay
    ar_delay = 3; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
    send_cmd(1'b0, 32'h14, 32'h0, 4'h0);
    wait_rsp(40);
    check("rd1_rdata", rsp_rdata, 32'h1234_5678);
    check("rd1_resp", rsp_resp, 0);
    check("rd1_araddr", got_araddr, 32'h14);
    check("rd1_arprot", arprot, 0);
    take_rsp();

    // SLVERR write, wready ahead of awready, then next command must be accepted
    aw_delay = 2; w_delay = 0; bresp_cfg = 2'b10;
    send_cmd(1'b1, 32'h20, 32'h0000_00A5, 4'h1);
    wait_rsp(40);
    check("wr2_resp", rsp_resp, 2'b10);
    check("wr2_timeout", rsp_timeout, 0);
    check("wr2_wstrb", got_wstrb, 4'h1);
    take_rsp();
    ar_delay = 0; rdata_cfg = 32'hA5A5_0F0F; rresp_cfg = 2'b01;
    send_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    wait_rsp(40);
    check("rd2_rdata", rsp_rdata, 32'hA5A5_0F0F);
    check("rd2_resp_exokay", rsp_resp, 2'b01);
    take_rsp();

    // DECERR read, rsp_ready held low for five cycles
    rdata_cfg = 32'h0BAD_CAFE; rresp_cfg = 2'b11;
    send_cmd(1'b0, 32'h28, 32'h0, 4'h0);
    wait_rsp(40);
    held = rsp_rdata;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== held || cmd_ready) stable = 0;
    end
    check("hold_stable", stable, 1);
    check("hold_rdata", rsp_rdata, 32'h0BAD_CAFE);
    check("hold_resp_decerr", rsp_resp, 2'b11);
    take_rsp();
    check("release_rsp_valid", rsp_valid, 0);
    check("release_cmd_ready", cmd_ready, 1);

`ifdef AXIL_CFG_TIMEOUT_EN
    // arready never arrives: watchdog aborts
    ar_en = 1'b0;
    send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
    wait_rsp(60);
    check("tmo_arvalid", arvalid, 0);
    check("tmo_resp", rsp_resp, 2'b10);
    check("tmo_flag", rsp_timeout, 1);
    check("tmo_rdata", rsp_rdata, 0);
    take_rsp();
    ar_en = 1'b1;
`endif

    // Reset while awvalid is high
    aw_delay = 20; w_delay = 20; bresp_cfg = 2'b00;
    send_cmd(1'b1, 32'h40, 32'h5555_AAAA, 4'hC);
    tick();
    check("mid_awvalid_before_rst", awvalid, 1);
    aresetn = 1'b0;
    tick();
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_bready", bready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    aresetn = 1'b1;
    tick();
    check("mid_rst_cmd_ready", cmd_ready, 1);
    no_rsp = 1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) no_rsp = 0;
      tick();
    end
    check("mid_rst_no_rsp", no_rsp, 1);

    // Recovery read
    aw_delay = 0; w_delay = 0; ar_delay = 0; rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b00;
    send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
    wait_rsp(40);
    check("recover_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("recover_resp", rsp_resp, 0);
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
